dds_sweep_ctrl: RTL and testbench

- Frequency-sweep sequencer for the NCO phase-accumulator datapath.
- Holds a programmable sweep profile: start word, stop word, step and dwell.
- On a start request it walks the 32-bit frequency tuning word from start to stop, in fixed steps with a fixed dwell per point.
- The tuning word drives the accumulator increment directly; the sine ROM lookup downstream is unchanged.

---
 rtl/dds_sweep_ctrl.sv | 150 +++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for the NCO phase accumulator.
// Walks the tuning word from start to stop in fixed steps, holding each point for a programmable dwell.
`timescale 1ns/1ps
module dds_sweep_ctrl #(
  parameter int FW_WIDTH     = 32,
  parameter int DWELL_WIDTH  = 16,
  parameter bit PHASE_CLR_EN = 1'b1
) (
  input  logic                   clk_50M,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [FW_WIDTH-1:0]    cfg_start,
  input  logic [FW_WIDTH-1:0]    cfg_stop,
  input  logic [FW_WIDTH-1:0]    cfg_step,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic                   cfg_mode,
  input  logic                   start,
  input  logic                   abort,
  output logic [FW_WIDTH-1:0]    freq_word,
  output logic                   freq_valid,
  output logic                   phase_clr,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [FW_WIDTH-1:0]    prof_start, prof_stop, prof_step;
  logic [DWELL_WIDTH-1:0] prof_dwell;
  logic                   prof_mode;
  logic                   dir_up;
  logic [DWELL_WIDTH-1:0] dwell_cnt;

  logic                   cfg_wr;
  logic [FW_WIDTH-1:0]    eff_start, eff_stop;
  logic [DWELL_WIDTH-1:0] dwell_eff;
  logic                   hold_done, last_point;
  logic [FW_WIDTH:0]      up_sum, down_diff;
  logic                   clamp;
  logic [FW_WIDTH-1:0]    next_point;

  logic                   load_first, advance;
  logic [FW_WIDTH-1:0]    freq_nxt;
  logic [DWELL_WIDTH-1:0] cnt_nxt;
  logic                   valid_nxt, pclr_nxt, done_nxt, dir_nxt;

  // A write coinciding with start must launch the sweep with the incoming values.
  assign cfg_wr    = cfg_valid && (state == IDLE);
  assign eff_start = cfg_wr ? cfg_start : prof_start;
  assign eff_stop  = cfg_wr ? cfg_stop  : prof_stop;

  assign dwell_eff  = (prof_dwell == '0) ? DWELL_WIDTH'(1) : prof_dwell;
  assign hold_done  = (dwell_cnt >= dwell_eff);
  assign last_point = (freq_word == prof_stop) || (prof_step == '0);

  // The extra carry/borrow bit catches wrap past either end of the word range.
  assign up_sum     = {1'b0, freq_word} + {1'b0, prof_step};
  assign down_diff  = {1'b0, freq_word} - {1'b0, prof_step};
  assign clamp      = dir_up ? (up_sum[FW_WIDTH] || (up_sum[FW_WIDTH-1:0] > prof_stop))
                             : (down_diff[FW_WIDTH] || (down_diff[FW_WIDTH-1:0] < prof_stop));
  assign next_point = clamp ? prof_stop
                            : (dir_up ? up_sum[FW_WIDTH-1:0] : down_diff[FW_WIDTH-1:0]);

  always_ff @(posedge clk_50M) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (hold_done && last_point && !prof_mode) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state == RUN);
    cfg_ready  = (state == IDLE);
    load_first = (state == IDLE) && start && !abort;
    advance    = (state == RUN) && !abort && hold_done;
    freq_nxt   = freq_word;
    cnt_nxt    = (state == RUN) ? dwell_cnt + DWELL_WIDTH'(1) : dwell_cnt;
    valid_nxt  = 1'b0;
    pclr_nxt   = 1'b0;
    done_nxt   = 1'b0;
    dir_nxt    = dir_up;
    if (load_first) begin
      freq_nxt  = eff_start;
      valid_nxt = 1'b1;
      pclr_nxt  = PHASE_CLR_EN;
      cnt_nxt   = DWELL_WIDTH'(1);
      dir_nxt   = (eff_stop >= eff_start);
    end else if (advance) begin
      cnt_nxt = DWELL_WIDTH'(1);
      if (!last_point) begin
        freq_nxt  = next_point;
        valid_nxt = 1'b1;
      end else if (prof_mode) begin
        freq_nxt  = prof_start;
        valid_nxt = 1'b1;
        pclr_nxt  = PHASE_CLR_EN;
      end else begin
        done_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      prof_start <= '0;
      prof_stop  <= '0;
      prof_step  <= '0;
      prof_dwell <= '0;
      prof_mode  <= 1'b0;
      dir_up     <= 1'b1;
      dwell_cnt  <= '0;
      freq_word  <= '0;
      freq_valid <= 1'b0;
      phase_clr  <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (cfg_wr) begin
        prof_start <= cfg_start;
        prof_stop  <= cfg_stop;
        prof_step  <= cfg_step;
        prof_dwell <= cfg_dwell;
        prof_mode  <= cfg_mode;
      end
      dir_up     <= dir_nxt;
      dwell_cnt  <= cnt_nxt;
      freq_word  <= freq_nxt;
      freq_valid <= valid_nxt;
      phase_clr  <= pclr_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: a point-list model predicts every freq_valid/done event
// and the number of cycles since the previous one; a monitor pops and compares as events appear.
`timescale 1ns/1ps
module tb_dds_sweep_ctrl;

  logic        clk_50M = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready;
  logic [31:0] cfg_start, cfg_stop, cfg_step;
  logic [15:0] cfg_dwell;
  logic        cfg_mode, start, abort;
  logic [31:0] freq_word;
  logic        freq_valid, phase_clr, busy, done;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int last_ev_cycle = 0;

  typedef struct {
    bit          is_done;
    logic [31:0] word;
    bit          pclr;
    int          gap;
  } ev_t;

  ev_t exp_q[$];

  dds_sweep_ctrl #(.FW_WIDTH(32), .DWELL_WIDTH(16), .PHASE_CLR_EN(1'b1)) dut (
    .clk_50M(clk_50M), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
    .start(start), .abort(abort),
    .freq_word(freq_word), .freq_valid(freq_valid), .phase_clr(phase_clr),
    .busy(busy), .done(done)
  );

  always #10 clk_50M = ~clk_50M;

  always @(posedge clk_50M) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Monitor: every freq_valid or done pulse must match the head of the expectation queue.
  always @(negedge clk_50M) begin
    ev_t e;
    if (!rst && (freq_valid || done)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_event: got word=%0h valid=%0b done=%0b required no event",
                 freq_word, freq_valid, done);
      end else begin
        e = exp_q.pop_front();
        check_output("event_is_done", {31'd0, done}, {31'd0, e.is_done});
        check_output("freq_word", freq_word, e.word);
        if (!e.is_done) check_output("phase_clr", {31'd0, phase_clr}, {31'd0, e.pclr});
        if (e.gap >= 0) check_output("hold_cycles", cycle - last_ev_cycle, e.gap);
      end
      last_ev_cycle = cycle;
    end
  end

  // Reference model: list the points with plain 64-bit arithmetic, then turn them into events.
  function automatic int push_sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                                    input int dw, input bit mode, input int passes,
                                    input int max_ev, input int first_gap);
    longint pts[$];
    longint cur, nxt, ls, le, lst;
    bit up;
    int hold, n;
    ev_t ev;
    ls = s; le = e; lst = st;
    up = (le >= ls);
    hold = (dw == 0) ? 1 : dw;
    cur = ls;
    while (1) begin
      pts.push_back(cur);
      if (cur == le || lst == 0) break;
      nxt = up ? cur + lst : cur - lst;
      if (up && nxt > le) nxt = le;
      if (!up && nxt < le) nxt = le;
      cur = nxt;
    end
    n = 0;
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < pts.size(); i++) begin
        if (n < max_ev) begin
          ev.is_done = 1'b0;
          ev.word    = 32'(pts[i]);
          ev.pclr    = (i == 0);
          ev.gap     = (p == 0 && i == 0) ? first_gap : hold;
          exp_q.push_back(ev);
          n++;
        end
      end
    end
    if (!mode && n < max_ev) begin
      ev.is_done = 1'b1;
      ev.word    = 32'(pts[pts.size()-1]);
      ev.pclr    = 1'b0;
      ev.gap     = hold;
      exp_q.push_back(ev);
      n++;
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic write_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                           input logic [15:0] dw, input logic m);
    cfg_start = s; cfg_stop = e; cfg_step = st; cfg_dwell = dw; cfg_mode = m;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                                input logic [15:0] dw, input logic m);
    write_cfg(s, e, st, dw, m);
    void'(push_sweep(s, e, st, int'(dw), m, 1, 1000, -1));
    pulse_start();
  endtask

  task automatic wait_queue_empty(input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk_50M);
    check_output("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && (exp_q.size() != 0 || busy); i++) @(negedge clk_50M);
    check_output("queue_drained", exp_q.size(), 0);
    check_output("idle_busy", {31'd0, busy}, 0);
    exp_q.delete();
  endtask

  task automatic run_sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                           input logic [15:0] dw, input logic m);
    apply_stimulus(s, e, st, dw, m);
    wait_drain(2000);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rs, re, rst_step, diff;
    int n2;
    rst = 1'b1; cfg_valid = 1'b0; cfg_start = '0; cfg_stop = '0; cfg_step = '0;
    cfg_dwell = '0; cfg_mode = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    check_output("reset_freq_word", freq_word, 0);
    check_output("reset_busy", {31'd0, busy}, 0);
    check_output("reset_cfg_ready", {31'd0, cfg_ready}, 1);
    check_output("reset_freq_valid", {31'd0, freq_valid}, 0);
    check_output("reset_done", {31'd0, done}, 0);
    check_output("reset_phase_clr", {31'd0, phase_clr}, 0);
    rst = 1'b0;
    tick();

    $display("[TB] up sweep with clamp");
    run_sweep(32'd8589935, 32'd42949673, 32'd8589935, 16'd3, 1'b0);

    $display("[TB] down sweep");
    run_sweep(32'd42949673, 32'd8589935, 32'd17179870, 16'd1, 1'b0);

    $display("[TB] continuous mode");
    write_cfg(32'd8589935, 32'd42949673, 32'd8589935, 16'd3, 1'b1);
    void'(push_sweep(32'd8589935, 32'd42949673, 32'd8589935, 3, 1'b1, 2, 1000, -1));
    pulse_start();
    wait_queue_empty(200);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("cont_abort_busy", {31'd0, busy}, 0);
    check_output("cont_abort_word", freq_word, 32'd42949673);
    repeat (4) tick();

    $display("[TB] abort mid-sweep");
    write_cfg(32'd8589935, 32'd42949673, 32'd8589935, 16'd3, 1'b0);
    void'(push_sweep(32'd8589935, 32'd42949673, 32'd8589935, 3, 1'b0, 1, 2, -1));
    pulse_start();
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("abort_busy", {31'd0, busy}, 0);
    check_output("abort_cfg_ready", {31'd0, cfg_ready}, 1);
    check_output("abort_word", freq_word, 32'd17179870);
    repeat (6) tick();
    check_output("abort_queue_empty", exp_q.size(), 0);
    check_output("abort_word_held", freq_word, 32'd17179870);

    $display("[TB] cfg write coincident with start, dwell 0");
    cfg_start = 32'd1000; cfg_stop = 32'd1000; cfg_step = 32'd77; cfg_dwell = 16'd0; cfg_mode = 1'b0;
    cfg_valid = 1'b1;
    start = 1'b1;
    void'(push_sweep(32'd1000, 32'd1000, 32'd77, 0, 1'b0, 1, 1000, -1));
    tick();
    cfg_valid = 1'b0;
    start = 1'b0;
    wait_drain(100);
    check_output("single_point_word", freq_word, 32'd1000);

    $display("[TB] wrap clamp and zero step");
    run_sweep(32'hFFFFFF00, 32'hFFFFFFF0, 32'h80, 16'd2, 1'b0);
    check_output("wrap_final_word", freq_word, 32'hFFFFFFF0);
    run_sweep(32'd5000, 32'd9000, 32'd0, 16'd2, 1'b0);

    $display("[TB] reset mid-run");
    write_cfg(32'd8589935, 32'd42949673, 32'd8589935, 16'd3, 1'b0);
    void'(push_sweep(32'd8589935, 32'd42949673, 32'd8589935, 3, 1'b0, 1, 2, -1));
    pulse_start();
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check_output("rst_run_word", freq_word, 0);
    check_output("rst_run_busy", {31'd0, busy}, 0);
    check_output("rst_run_cfg_ready", {31'd0, cfg_ready}, 1);
    check_output("rst_run_queue", exp_q.size(), 0);
    rst = 1'b0;
    tick();
    void'(push_sweep(32'd0, 32'd0, 32'd0, 0, 1'b0, 1, 1000, -1));
    pulse_start();
    wait_drain(100);

    $display("[TB] start and cfg while busy");
    write_cfg(32'd8589935, 32'd42949673, 32'd8589935, 16'd3, 1'b0);
    void'(push_sweep(32'd8589935, 32'd42949673, 32'd8589935, 3, 1'b0, 1, 1000, -1));
    pulse_start();
    repeat (2) tick();
    pulse_start();
    check_output("busy_cfg_ready", {31'd0, cfg_ready}, 0);
    write_cfg(32'd123, 32'd456, 32'd7, 16'd9, 1'b1);
    wait_drain(200);
    void'(push_sweep(32'd8589935, 32'd42949673, 32'd8589935, 3, 1'b0, 1, 1000, -1));
    pulse_start();
    wait_drain(200);

    $display("[TB] start held high restarts after done");
    write_cfg(32'd42949673, 32'd8589935, 32'd17179870, 16'd1, 1'b0);
    void'(push_sweep(32'd42949673, 32'd8589935, 32'd17179870, 1, 1'b0, 1, 1000, -1));
    n2 = push_sweep(32'd42949673, 32'd8589935, 32'd17179870, 1, 1'b0, 1, 1000, 1);
    start = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() >= n2; i++) @(negedge clk_50M);
    start = 1'b0;
    wait_drain(200);

    $display("[TB] randomized sweeps");
    for (int t = 0; t < 24; t++) begin
      rs = $urandom;
      re = $urandom;
      diff = (re >= rs) ? re - rs : rs - re;
      if ($urandom_range(0, 7) == 0) rst_step = 32'd0;
      else rst_step = diff / 32'($urandom_range(1, 6)) + 32'($urandom_range(0, 3));
      run_sweep(rs, re, rst_step, 16'($urandom_range(0, 3)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
